// File: rtl/key_expansion.sv
// key_expansion -- AES-128 key schedule generator.
//
// On a start pulse in IDLE the block captures key_in. It then presents the
// 11 round keys (round 0 = the cipher key, up to round 10) on round_key, one
// per advance. All 16 bytes of the next key are computed in one cycle.
//
// Optional feature macro: KEY_EXP_STALL_EN
//   When defined, the rk_ready input is added. A key advances only on a
//   cycle with rk_valid=1 and rk_ready=1. While a key is not accepted, the
//   key, its index, rcon and done stay stable.
//   When undefined, rk_ready does not exist and every presented key is
//   accepted at once.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    synchronous active-low reset
//   start      in   1    begin an expansion (accepted in IDLE only)
//   key_in     in   128  cipher key, byte 0 in [127:120]
//   rk_ready   in   1    consumer accept (KEY_EXP_STALL_EN only)
//   round_key  out  128  current round key
//   round_idx  out  4    round number of round_key, 0..10
//   rk_valid   out  1    round_key/round_idx valid
//   busy       out  1    expansion in progress
//   done       out  1    high while round 10 is presented

// aes_sbox -- combinational AES forward S-box.
//   i_byte  in   8  input byte
//   o_byte  out  8  substituted byte
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    o_byte = SBOX[i_byte];
  end

endmodule

module key_expansion (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
`ifdef KEY_EXP_STALL_EN
  input  logic         rk_ready,
`endif
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [127:0] r_key;
  logic [3:0]   r_idx;
  logic [7:0]   r_rcon;

  logic         w_ready;
  logic         w_adv;
  logic         w_last;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_t;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [7:0]   w_rcon_nxt;

`ifdef KEY_EXP_STALL_EN
  assign w_ready = rk_ready;
`else
  assign w_ready = 1'b1;
`endif

  // A key is consumed on any EXPAND cycle where the consumer accepts it.
  assign w_adv  = (r_state == EXPAND) && w_ready;
  assign w_last = (r_idx == LAST_IDX);

  // ---------------------------------------------------------------------
  // Next-key datapath: t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  // ---------------------------------------------------------------------
  assign w_w0  = r_key[127:96];
  assign w_w1  = r_key[95:64];
  assign w_w2  = r_key[63:32];
  assign w_w3  = r_key[31:0];
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  aes_sbox u_sbox0 (.i_byte(w_rot[31:24]), .o_byte(w_sub[31:24]));
  aes_sbox u_sbox1 (.i_byte(w_rot[23:16]), .o_byte(w_sub[23:16]));
  aes_sbox u_sbox2 (.i_byte(w_rot[15:8]),  .o_byte(w_sub[15:8]));
  aes_sbox u_sbox3 (.i_byte(w_rot[7:0]),   .o_byte(w_sub[7:0]));

  assign w_t  = w_sub ^ {r_rcon, 24'h000000};
  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_n0 ^ w_w1;
  assign w_n2 = w_n1 ^ w_w2;
  assign w_n3 = w_n2 ^ w_w3;

  // xtime: multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        if (w_adv && w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    rk_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    if (r_state == EXPAND) begin
      rk_valid = 1'b1;
      busy     = 1'b1;
      done     = w_last;
    end
  end

  assign round_key = r_key;
  assign round_idx = r_idx;

  // ---------------------------------------------------------------------
  // Key / index / rcon registers
  // ---------------------------------------------------------------------
  // Acceptance of round 10 leaves the key in place so IDLE keeps showing
  // the last round key; rcon is reloaded on the next start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key  <= '0;
      r_idx  <= '0;
      r_rcon <= RCON_INIT;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_key  <= key_in;
        r_idx  <= '0;
        r_rcon <= RCON_INIT;
      end
    end else if (w_adv && !w_last) begin
      r_key  <= {w_n0, w_n1, w_n2, w_n3};
      r_idx  <= r_idx + 4'd1;
      r_rcon <= w_rcon_nxt;
    end
  end

endmodule

// File: tb/tb_key_expansion.sv
module tb_key_expansion;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid;
  logic         busy;
  logic         done;

  int n_tests;
  int n_fail;

  logic [127:0] exp_k [0:10];

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] JUNK    = 128'hdeadbeefcafef00d0123456789abcdef;

  key_expansion dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
`ifdef KEY_EXP_STALL_EN
    .rk_ready  (rk_ready),
`endif
    .round_key (round_key),
    .round_idx (round_idx),
    .rk_valid  (rk_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the full output set for an active cycle.
  task automatic chk_active(input string tag, input logic [127:0] k, input int idx);
    chk({tag, " key"},   round_key, k);
    chk({tag, " idx"},   {124'd0, round_idx}, 128'(idx));
    chk({tag, " valid"}, {127'd0, rk_valid}, 128'd1);
    chk({tag, " busy"},  {127'd0, busy}, 128'd1);
    chk({tag, " done"},  {127'd0, done}, (idx == 10) ? 128'd1 : 128'd0);
  endtask

  task automatic chk_idle(input string tag, input logic [127:0] k);
    chk({tag, " key"},   round_key, k);
    chk({tag, " valid"}, {127'd0, rk_valid}, 128'd0);
    chk({tag, " busy"},  {127'd0, busy}, 128'd0);
    chk({tag, " done"},  {127'd0, done}, 128'd0);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b1;

    exp_k[0]  = KEY_A;
    exp_k[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_k[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_k[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_k[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_k[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_k[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_k[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_k[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_k[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_k[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Reset state
    step();
    step();
    chk_idle("reset", 128'd0);
    chk("reset idx", {124'd0, round_idx}, 128'd0);
    rst_n = 1'b1;
    step();
    chk_idle("post-reset idle", 128'd0);

    // Run A: FIPS-197 key, key_in scrambled after capture, stray starts at
    // T+5 and in the done cycle T+11.
    key_in = KEY_A;
    start  = 1'b1;
    step();                       // now cycle T+1
    start  = 1'b0;
    key_in = JUNK;
    for (int i = 0; i <= 10; i++) begin
      chk_active($sformatf("runA r%0d", i), exp_k[i], i);
      if (i == 4 || i == 10) start = 1'b1;   // cycles T+5 and T+11
      step();
      start = 1'b0;
    end
    // Cycle T+12: idle, last key held
    chk_idle("runA T+12", exp_k[10]);

    // Back-to-back: zero key started in the first IDLE cycle
    key_in = '0;
    start  = 1'b1;
    step();                       // T+13
    start  = 1'b0;
    chk_active("zero r0", 128'd0, 0);
    step();
    chk_active("zero r1", 128'h62636363626363636263636362636363, 1);
    step();
    chk_active("zero r2", 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 2);
    for (int i = 3; i <= 10; i++) step();
    chk("zero r10 idx",  {124'd0, round_idx}, 128'd10);
    chk("zero r10 done", {127'd0, done}, 128'd1);
    step();
    chk("zero end busy", {127'd0, busy}, 128'd0);

    // Back-to-back with a third key: rcon must restart at 01
    key_in = KEY_B;
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk_active("keyB r0", KEY_B, 0);
    step();
    chk_active("keyB r1", 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 1);
    for (int i = 2; i <= 10; i++) step();
    chk_active("keyB r10", 128'h13111d7fe3944a17f307a78b4d2b30c5, 10);
    step();
    chk_idle("keyB end", 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Reset at T+4 of a run
    key_in = KEY_A;
    start  = 1'b1;
    step();                       // T+1
    start  = 1'b0;
    step();                       // T+2
    step();                       // T+3
    step();                       // T+4
    chk_active("abort r3", exp_k[3], 3);
    rst_n = 1'b0;
    start = 1'b1;                 // reset wins over start
    step();                       // T+5
    start = 1'b0;
    rst_n = 1'b1;
    chk_idle("abort T+5", 128'd0);
    chk("abort idx", {124'd0, round_idx}, 128'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("abort quiet%0d", i), 128'd0);
    end

    // Fresh expansion after reset must be bit-exact
    key_in = KEY_A;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      chk_active($sformatf("rerun r%0d", i), exp_k[i], i);
      step();
    end
    chk_idle("rerun end", exp_k[10]);

`ifdef KEY_EXP_STALL_EN
    // Backpressure: 3 stall cycles at round 4, 2 at round 10
    key_in = KEY_A;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      chk_active($sformatf("stall r%0d", i), exp_k[i], i);
      if (i == 4 || i == 10) begin
        rk_ready = 1'b0;
        for (int s = 0; s < ((i == 4) ? 3 : 2); s++) begin
          step();
          chk_active($sformatf("stall hold r%0d c%0d", i, s), exp_k[i], i);
        end
        rk_ready = 1'b1;
      end
      step();
    end
    chk_idle("stall end", exp_k[10]);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 The block SHALL have one clock and SHALL use a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  single-cycle request to begin an expansion.
REQ-005 key_in  input  128  AES-128 cipher key, with byte 0 in bits [127:120].
REQ-006 rk_ready  input  1  consumer accept signal; present only when KEY_EXP_STALL_EN is defined.
REQ-007 round_key  output  128  current round key, same byte order as key_in.
REQ-008 round_idx  output  4  index of round_key, range 0..10.
REQ-009 rk_valid  output  1  round_key/round_idx valid this cycle.
REQ-010 busy  output  1  expansion in progress.
REQ-011 done  output  1  single-cycle pulse, coincident with round 10.

Function
REQ-012 The FSM SHALL have two states: IDLE and EXPAND.
REQ-013 In IDLE with start=1, the block SHALL capture key_in and enter EXPAND on the next edge.
REQ-014 The first cycle in EXPAND SHALL present round_key=key_in, round_idx=0, rk_valid=1 and busy=1, one cycle after start.
REQ-015 Each advance SHALL compute the next key from current words w0..w3 as t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
- n0 = w0^t, n1 = n0^w1, n2 = n1^w2, n3 = n2^w3.
- All 16 bytes of n0..n3 SHALL be computed in the same cycle.
REQ-016 SubWord SHALL use four instances of the team's existing combinational S-box module, one per byte of the rotated word.
REQ-017 rcon SHALL be a register that resets to 8'h01 and advances by GF(2^8) xtime per round.
- Sequence: 01,02,04,08,10,20,40,80,1B,36.
- rcon SHALL reload to 8'h01 on each accepted start.
REQ-018 Without stall, round_idx SHALL increment by one every cycle, so 11 keys appear on 11 consecutive cycles.
REQ-019 When round_idx=10 is presented, the block SHALL assert done=1 for that one cycle.
REQ-020 The block SHALL return to IDLE on the following edge, with rk_valid=0 and busy=0.
REQ-021 start SHALL be ignored while busy=1, including in the done cycle.
REQ-022 The block SHALL accept a new start on the first cycle after done, i.e. the first IDLE cycle.
REQ-023 key_in changes after capture SHALL NOT affect the expansion in progress.
REQ-024 In IDLE, round_key SHALL hold its last value and rk_valid, done and busy SHALL be 0.

Reset
REQ-025 With rst_n=0 at an edge, the block SHALL enter IDLE and set round_key=0, round_idx=0, rk_valid=0, busy=0, done=0 and rcon=8'h01.
REQ-026 Reset asserted mid-expansion SHALL abort the expansion with no further rk_valid, and SHALL take priority over start.

Configuration
REQ-027 Defining KEY_EXP_STALL_EN SHALL add the rk_ready port and backpressure.
- Advance occurs only on a cycle with rk_valid=1 and rk_ready=1.
- While rk_valid=1 and rk_ready=0, round_key, round_idx, rcon and done SHALL hold stable.
- done SHALL remain asserted until round 10 is accepted.
- The return to IDLE SHALL follow the round-10 acceptance.
REQ-028 Without KEY_EXP_STALL_EN, the rk_ready port SHALL NOT exist and the block SHALL behave as if rk_ready=1.

Verification
REQ-029 key_in=2b7e151628aed2a6abf7158809cf4f3c with start at cycle T -> the bench SHALL check all of the following:
- idx0 = key_in at T+1.
- idx1 = a0fafe1788542cb123a339392a6c7605 at T+2.
- idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with done=1 at T+11.
- busy=0 at T+12.
REQ-030 key_in=0 -> the bench SHALL check idx1 = 62636363626363636263636362636363.
REQ-031 start pulsed at T+5 and at T+11 during a run -> the bench SHALL check the output sequence is unchanged.
- A start at T+12 SHALL begin a new expansion with idx0 at T+13.
REQ-032 rst_n=0 at T+4 of a run -> the bench SHALL check that all outputs are 0 at T+5 and stay 0 with no start.
- A subsequent expansion SHALL be bit-exact with REQ-029.
REQ-033 With KEY_EXP_STALL_EN, hold rk_ready=0 for 3 cycles at idx4 and for 2 cycles at idx10 -> the bench SHALL check that:
- keys are held stable during each stall;
- done stays high until idx10 is accepted;
- the key sequence matches REQ-029.
REQ-034 A back-to-back expansion with a new key_in -> the bench SHALL check that rcon restarts at 01.
- idx1 SHALL match the software model for the new key.
